// File: rtl/serial_arb_pkg.sv
// Shared types and defaults for the two-requester serial transfer arbiter.
package serial_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DELAY = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; remembers the last served requester.
module rr_arb2
  import serial_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served,
  output logic       win
);

  logic last;

  // last=1 after reset so requester 0 is favoured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= served;
    end
  end

  assign win = (&req) ? ~last : req[1];

endmodule

// File: rtl/serial_arb_ctrl.sv
// Arbitrates two requesters onto one serial d->q chain and reassembles the word.
// Optional SERIAL_ARB_CHECK_EN adds err: loopback word differs from sent word.
module serial_arb_ctrl
  import serial_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DELAY = DEF_DELAY
) (
`ifdef SERIAL_ARB_CHECK_EN
  output logic             err,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] word0,
  input  logic [WIDTH-1:0] word1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] rx_word,
  output logic             d_out,
  input  logic             q_in,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + DELAY + 1);
  localparam logic [CW-1:0] LAST_SH = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DR = CW'(WIDTH + DELAY - 1);
  localparam logic [CW-1:0] CAP0 = CW'(DELAY);

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_sh;
  logic [WIDTH-1:0] rx_sh;
  logic             owner;
  logic             win;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .upd    (state == DONE),
    .served (owner),
    .win    (win)
  );

  assign word_sh = word_q >> cnt;

  // capture shifts in from the top so the first bit ends at the LSB
  always_comb begin
    rx_sh = rx_word >> 1;
    rx_sh[WIDTH-1] = q_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      word_q  <= '0;
      owner   <= 1'b0;
      rx_word <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req != 2'b00) begin
        word_q <= win ? word1 : word0;
        owner  <= win;
        cnt    <= '0;
      end else if (state == SHIFT || state == DRAIN) begin
        cnt <= cnt + 1'b1;
        if (cnt >= CAP0) begin
          rx_word <= rx_sh;
        end
      end
    end
  end

  always_comb begin
    nxt   = state;
    d_out = 1'b0;
    gnt   = 2'b00;
    done  = 2'b00;
    busy  = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (req != 2'b00) nxt = SHIFT;
      end
      SHIFT: begin
        d_out = word_sh[0];
        if (cnt == '0) gnt = owner ? 2'b10 : 2'b01;
        if (cnt == LAST_SH) nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt == LAST_DR) nxt = DONE;
      end
      DONE: begin
        done = owner ? 2'b10 : 2'b01;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

`ifdef SERIAL_ARB_CHECK_EN
  assign err = (state == DONE) && (rx_word != word_q);
`endif

endmodule

// File: tb/tb_serial_arb_ctrl.sv
// Randomized bench for serial_arb_ctrl with a DELAY-stage flop chain loopback.
module tb_serial_arb_ctrl;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] word0, word1;
  logic [1:0]   gnt, done;
  logic [W-1:0] rx_word;
  logic         d_out, q_in, busy;
  logic [D-1:0] chain = '0;
  bit           kill;
`ifdef SERIAL_ARB_CHECK_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;
  bit prio;

  serial_arb_ctrl #(.WIDTH(W), .DELAY(D)) dut (
`ifdef SERIAL_ARB_CHECK_EN
    .err     (err),
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .word0   (word0),
    .word1   (word1),
    .gnt     (gnt),
    .done    (done),
    .rx_word (rx_word),
    .d_out   (d_out),
    .q_in    (q_in),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) chain <= {chain[D-2:0], d_out};
  assign q_in = kill ? 1'b0 : chain[D-1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    prio = 1'b0;
    tick();
  endtask

  task automatic xfer(input logic [1:0] r, input logic [W-1:0] w0,
                      input logic [W-1:0] w1, input bit hold, input bit kl);
    logic         win;
    logic [W-1:0] wexp, rexp, dbits;
    bit           drn, seen;
    int           k;
    win  = (r == 2'b11) ? prio : r[1];
    wexp = win ? w1 : w0;
    rexp = kl ? '0 : wexp;
    req = r;
    word0 = w0;
    word1 = w1;
    kill = kl;
    chk("idle_busy", 32'(busy), 0);
    tick();
    chk("gnt", 32'(gnt), win ? 2 : 1);
    chk("busy", 32'(busy), 1);
    word0 = W'($urandom);
    word1 = W'($urandom);
    req = 2'($urandom_range(1, 3));
    dbits = '0;
    drn = 0;
    seen = 0;
    for (k = 0; k < 40; k++) begin
      if (k < W) dbits[k] = d_out;
      else if (k < W + D) drn |= d_out;
      if (k == 1) chk("gnt_pulse", 32'(gnt), 0);
      if (done != 2'b00) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("done_seen", 32'(seen), 1);
    chk("latency", 32'(k), W + D);
    chk("done", 32'(done), win ? 2 : 1);
    chk("rx_word", 32'(rx_word), 32'(rexp));
    chk("d_serial", 32'(dbits), 32'(wexp));
    chk("drain_zero", 32'(drn), 0);
`ifdef SERIAL_ARB_CHECK_EN
    chk("err", 32'(err), 32'(rexp != wexp));
`endif
    prio = ~win;
    req = hold ? r : 2'b00;
    kill = 0;
    tick();
    chk("idle_after", 32'(busy), 0);
    chk("idle_dout", 32'(d_out), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req = 2'b00;
    word0 = '0;
    word1 = '0;
    kill = 0;
    prio = 0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout", 32'(d_out), 0);
    chk("rst_rx", 32'(rx_word), 0);
    rst_n = 1'b1;
    tick();

    xfer(2'b01, 8'hA5, 8'h00, 0, 0);

    do_reset();
    xfer(2'b11, 8'h3C, 8'hC3, 1, 0);
    xfer(2'b11, 8'h3C, 8'hC3, 0, 0);

    for (int i = 0; i < 4; i++) begin
      xfer(2'b11, W'($urandom), W'($urandom), 1, 0);
    end

    req = 2'b01;
    word0 = 8'h5A;
    word1 = 8'h11;
    tick();
    chk("mid_gnt", 32'(gnt), 1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_dout", 32'(d_out), 0);
    chk("mid_rst_rx", 32'(rx_word), 0);
    req = 2'b00;
    tick();
    chk("mid_rst_nodone", 32'(done), 0);
    rst_n = 1'b1;
    prio = 0;
    tick();
    chk("post_rst_idle", 32'(busy), 0);
    xfer(2'b10, 8'h77, 8'h96, 0, 0);

`ifdef SERIAL_ARB_CHECK_EN
    xfer(2'b01, 8'hFF, 8'h00, 0, 1);
`endif

    for (int i = 0; i < 16; i++) begin
      xfer(2'($urandom_range(1, 3)), W'($urandom), W'($urandom),
           bit'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_arb_ctrl.md
SERIAL_ARB_CTRL -- requirements
Module: serial_arb_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per transferred word.
REQ-002 Parameter DELAY, default 3: fixed latency, in clk cycles, of the shared serial flip-flop chain (d -> q).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req[1:0]  input  2  per-requester transfer request; level, held until done.
REQ-006 word0, word1  input  WIDTH each  word to send for requester 0 and 1; sampled at grant.
REQ-007 gnt[1:0]  output  2  one-cycle one-hot grant pulse.
REQ-008 done[1:0]  output  2  one-cycle one-hot completion pulse.
REQ-009 rx_word  output  WIDTH  word reassembled from the chain; valid only while done is nonzero.
REQ-010 d_out  output  1  serial bit driven into the chain's d input.
REQ-011 q_in  input  1  serial bit from the chain's q output.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DRAIN and DONE.
REQ-014 IDLE: on an edge with req != 0, latch the winner's word, pulse gnt[winner] for the following cycle, clear the bit counter, and go to SHIFT.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset requester 0 wins.
REQ-016 SHIFT: d_out = latched word bit [cnt], LSB first, cnt 0..WIDTH-1; after WIDTH cycles go to DRAIN.
REQ-017 DRAIN: d_out = 0 for DELAY cycles, then go to DONE.
REQ-018 Capture: in SHIFT/DRAIN cycle t (t = 0 at SHIFT entry), for DELAY <= t < DELAY+WIDTH, q_in SHALL be stored as rx_word bit [t-DELAY].
REQ-019 DONE: pulse done[winner] for one cycle with rx_word valid, update the round-robin pointer, and return to IDLE.
REQ-020 From request to done, the transfer SHALL take exactly 1 + WIDTH + DELAY + 1 cycles; IDLE is held for at least one cycle between transfers.
REQ-021 req changes during SHIFT/DRAIN/DONE SHALL be ignored; the latched word SHALL NOT change.
REQ-022 In IDLE, d_out = 0 and rx_word holds its last value.

Reset
REQ-023 While rst_n = 0: state IDLE; gnt, done, busy, d_out = 0; rx_word = 0; counter = 0; round-robin pointer favours requester 0.
REQ-024 Reset asserted mid-transfer SHALL abort it immediately, and no done SHALL be issued for it.

Configuration
REQ-025 Macro SERIAL_ARB_CHECK_EN: when defined, add output err (1 bit, reset 0), which pulses in DONE iff rx_word != latched word. When undefined, no err port and no compare logic.

Structure
REQ-026 A shared package serial_arb_pkg SHALL hold the state enum typedef and the default WIDTH/DELAY constants.
REQ-027 The round-robin winner/pointer logic SHALL be a sub-module, rr_arb2.

Verification
REQ-028 Bench pairs the block with a DELAY-stage D flip-flop chain driven by d_out and returning on q_in.
REQ-029 Single request: req=01, word0=8'hA5 -> gnt=01 for 1 cycle; done=01 after 13 cycles total; rx_word=8'hA5.
REQ-030 Simultaneous request: req=11, word0=8'h3C, word1=8'hC3 -> requester 0 served first (rx 8'h3C), then requester 1 (rx 8'hC3).
REQ-031 Fairness: hold req=11 for four transfers -> grant order 0,1,0,1.
REQ-032 Reset mid-transfer: rst_n low during SHIFT cycle 4 -> outputs return to 0 at once; no done; after release, req=10 gets the next grant.
REQ-033 Check enabled: force q_in to 0 and send 8'hFF -> rx_word=8'h00, err pulses with done.
